// File: rtl/uart_byte_receiver.sv
`timescale 1ns/1ps
// rtl/uart_byte_receiver.sv - 8N1 UART receiver: 2-FF sync, glitch rejection, mid-bit sampling, stop check
module uart_byte_receiver #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_error,
   output logic       busy
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_cfg_check
         $error("uart_byte_receiver: CLKS_PER_BIT must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t           state_q, state_d;
   logic [1:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       sreg_q, sreg_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             rx_s;
   logic             tick_half;
   logic             tick_bit;

   assign rx_s      = sync_q[1];
   assign tick_half = (cnt_q == HALF_LAST);
   assign tick_bit  = (cnt_q == BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!rx_s) state_d = S_START;
         S_START: if (tick_half) state_d = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (tick_bit && idx_q == 3'd7) state_d = S_STOP;
         S_STOP:  if (tick_bit) state_d = rx_s ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The counter also restarts at each data-bit boundary, since DATA spans eight bit periods.
   always_comb begin
      sync_d  = {sync_q[0], uart_rx};
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      sreg_d  = sreg_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      if (state_d != state_q || (state_q == S_DATA && tick_bit)) begin
         cnt_d = '0;
      end
      if (state_q == S_START) begin
         idx_d = 3'd0;
      end
      if (state_q == S_DATA && tick_bit) begin
         sreg_d = {rx_s, sreg_q[7:1]};
         idx_d  = idx_q + 3'd1;
      end
      if (state_q == S_STOP && tick_bit) begin
         valid_d = rx_s;
         ferr_d  = !rx_s;
      end
      data_d = valid_d ? sreg_q : data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         sreg_q  <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sreg_q  <= sreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign frame_error = ferr_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
`timescale 1ns/1ps
// tb/tb_uart_byte_receiver.sv - scoreboard bench for uart_byte_receiver with directed and random frames
module tb_uart_byte_receiver;
   localparam int  CLK_FREQ = 100_000_000;
   localparam int  BAUD     = 3_125_000;
   localparam int  CPB      = CLK_FREQ / BAUD;
   localparam real TCLK     = 10.0;
   localparam real BIT_NS   = 1.0e9 / BAUD;
   localparam real LAT_MIN  = 9.5 * CPB * TCLK;
   localparam real LAT_MAX  = (9.5 * CPB + 3.0) * TCLK;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_error;
   logic       busy;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      realtime    t_start;
   } exp_t;

   exp_t       exp_q[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] last_good = 8'h00;
   bit         prev_strobe = 1'b0;

   uart_byte_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
      .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .rx_data(rx_data),
      .rx_valid(rx_valid), .frame_error(frame_error), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: every whole frame yields one strobe; a good stop delivers the byte,
   // a bad stop reports an error while the last good byte stays visible.
   task automatic send_frame(input logic [7:0] b, input bit stop, input real bit_ns);
      exp_t e;
      e.t_start = $realtime;
      e.is_err  = !stop;
      e.data    = stop ? b : last_good;
      if (stop) last_good = b;
      exp_q.push_back(e);
      uart_rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         #(bit_ns);
      end
      uart_rx = stop;
      #(bit_ns);
      uart_rx = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 6000 && exp_q.size() != 0; i++) @(negedge clk);
      chk({name, "_drain"}, exp_q.size(), 0);
      if (exp_q.size() != 0) exp_q.delete();
   endtask

   always @(negedge clk) begin
      exp_t e;
      realtime lat;
      if (!rst_n) begin
         prev_strobe = 1'b0;
      end else begin
         if (rx_valid || frame_error) begin
            chk("strobe_exclusive", {30'd0, rx_valid && frame_error, prev_strobe}, 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", {30'd0, rx_valid, frame_error}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("strobe_kind", {30'd0, rx_valid, frame_error}, e.is_err ? 32'd1 : 32'd2);
               chk("rx_data", rx_data, e.data);
               lat = $realtime - TCLK / 2.0 - e.t_start;
               checks++;
               if (lat < LAT_MIN || lat > LAT_MAX) begin
                  errors++;
                  $display("FAIL latency: got %0.1f ns, expected %0.1f..%0.1f ns", lat, LAT_MIN, LAT_MAX);
               end
            end
         end
         prev_strobe = rx_valid || frame_error;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      bit         stop;
      real        bn;
      int         gap;

      repeat (4) @(negedge clk);
      chk("reset_rx_data", rx_data, 8'h00);
      chk("reset_strobes", {30'd0, rx_valid, frame_error}, 0);
      chk("reset_busy", busy, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      send_frame(8'hA5, 1'b1, BIT_NS);
      wait_drain("t1");
      chk("t1_busy_idle", busy, 0);
      chk("t1_data", rx_data, 8'hA5);

      send_frame(8'h00, 1'b1, BIT_NS);
      send_frame(8'hFF, 1'b1, BIT_NS);
      wait_drain("t2");

      #(BIT_NS);
      uart_rx = 1'b0;
      #(6 * TCLK);
      chk("t3_busy_high", busy, 1);
      #(4 * TCLK);
      uart_rx = 1'b1;
      #(2 * BIT_NS);
      chk("t3_busy_low", busy, 0);

      send_frame(8'h11, 1'b1, BIT_NS);
      send_frame(8'h5A, 1'b0, BIT_NS);
      #(BIT_NS);
      wait_drain("t4");
      chk("t4_data_held", rx_data, 8'h11);

      begin
         exp_t e;
         e.t_start = $realtime;
         e.is_err  = 1'b1;
         e.data    = last_good;
         exp_q.push_back(e);
      end
      uart_rx = 1'b0;
      #(20 * BIT_NS);
      uart_rx = 1'b1;
      #(BIT_NS);
      send_frame(8'h3C, 1'b1, BIT_NS);
      wait_drain("t5");

      b = 8'h96;
      uart_rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         uart_rx = b[i];
         #(BIT_NS);
      end
      uart_rx = b[4];
      #(BIT_NS / 2.0);
      rst_n = 1'b0;
      uart_rx = 1'b1;
      last_good = 8'h00;
      #(3 * TCLK);
      chk("t6_reset_data", rx_data, 8'h00);
      chk("t6_reset_busy", busy, 0);
      chk("t6_reset_strobes", {30'd0, rx_valid, frame_error}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #(12 * BIT_NS);
      chk("t6_no_strobe_data", rx_data, 8'h00);
      send_frame(8'hC3, 1'b1, BIT_NS);
      wait_drain("t6");

      send_frame(8'hA5, 1'b1, BIT_NS * 0.98);
      send_frame(8'hA5, 1'b1, BIT_NS * 1.02);
      wait_drain("t7");
      chk("t7_busy_idle", busy, 0);

      for (int n = 0; n < 16; n++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         case ($urandom_range(0, 2))
            0:       bn = BIT_NS * 0.98;
            1:       bn = BIT_NS;
            default: bn = BIT_NS * 1.02;
         endcase
         send_frame(b, stop, bn);
         gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         #(gap * bn);
      end
      #(BIT_NS);
      wait_drain("rand");
      chk("final_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
